// File: rtl/mem_if_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Package     : mem_if_pkg
//  Description : Types and constants shared by the processor's load/store
//                request port and the memory-side responder. Holds the
//                responder state encoding and the default word and address
//                widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

  // Default widths of the load/store channel. The core's request port uses
  // these same values.
  localparam int c_DATA_W = 16;
  localparam int c_ADDR_W = 8;

  // Responder states. The encoding 2'd3 is unused and is treated as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sp_ram.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : sp_ram
//  Description : Single-port synchronous RAM with a registered read. There
//                is no reset, so contents persist across responder resets.
//                A write and a read on the same edge return the old word.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk    in   rising-edge clock
//    we     in   write enable
//    addr   in   word address (ADDR_W bits)
//    wdata  in   write data (DATA_W bits)
//    rdata  out  registered read data: the word at addr before this edge
// ============================================================================
module sp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Memory-side responder for the load/store request channel.
//                It accepts one request at a time and inserts WAIT_CYCLES
//                wait states. It then performs the read or write on an
//                internal word-addressed RAM and holds a response until the
//                core takes it.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk        in   rising-edge clock
//    reset      in   asynchronous active-low reset
//    req_valid  in   request present
//    req_ready  out  responder can accept a request (IDLE only)
//    req_we     in   1 = write, 0 = read
//    req_addr   in   word address
//    req_wdata  in   write data
//    rsp_valid  out  response present
//    rsp_ready  in   core accepts the response
//    rsp_rdata  out  read data; 0 for writes and out-of-range accesses
//    rsp_err    out  address >= DEPTH
// ============================================================================
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int DATA_W      = c_DATA_W,
  parameter int ADDR_W      = c_ADDR_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              r_ready_en;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic              r_rd;
  logic              w_accept;
  logic              w_enter_resp;
  logic              w_in_range;
  logic              w_ram_we;
  logic [DATA_W-1:0] w_ram_rdata;

  // r_ready_en keeps req_ready low until the first edge after reset release.
  assign w_accept = (r_state == IDLE) && r_ready_en && req_valid;

  // The accept edge only captures the request. The counter is loaded with
  // WAIT_CYCLES and the RAM access happens on the edge after it reaches 0.
  // A request accepted at edge N is therefore answered after edge
  // N+WAIT_CYCLES+1.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = 4'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready_en <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err      <= 1'b0;
      r_rd       <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_enter_resp) begin
        r_err <= !w_in_range;
        r_rd  <= !r_we && w_in_range;
      end else if ((r_state == RESP) && rsp_ready) begin
        r_err <= 1'b0;
        r_rd  <= 1'b0;
      end
    end
  end

  // Zero-extended compare. With a fully populated address space every
  // address is valid, so no comparator is built.
  generate
    if (DEPTH >= (1 << ADDR_W)) begin : g_full_range
      assign w_in_range = 1'b1;
    end else begin : g_part_range
      assign w_in_range = ({1'b0, r_addr} < (ADDR_W + 1)'(DEPTH));
    end
  endgenerate

  // A reset drops the state to IDLE, so a write that has not yet reached
  // the RAM edge is discarded.
  assign w_ram_we = w_enter_resp && r_we && w_in_range;

  sp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (r_addr),
    .wdata (r_wdata),
    .rdata (w_ram_rdata)
  );

  // The RAM keeps re-reading r_addr. r_addr is frozen outside IDLE and no
  // write happens during RESP, so the gated read data stays stable until
  // the response is taken.
  assign req_ready = (r_state == IDLE) && r_ready_en;
  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = r_err;
  assign rsp_rdata = r_rd ? w_ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder. Three instances
//                cover WAIT_CYCLES=2/DEPTH=200, WAIT_CYCLES=0/DEPTH=256 and
//                WAIT_CYCLES=4/DEPTH=256. Each request pushes its expected
//                response, computed from an array model of memory, into a
//                per-instance queue. A monitor per instance compares and
//                retires responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int N_DUT = 3;

  function automatic int depth_of(input int k);
    return (k == 0) ? 200 : 256;
  endfunction

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 0 : 4);
  endfunction

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [N_DUT];
  logic        req_ready [N_DUT];
  logic        req_we    [N_DUT];
  logic [7:0]  req_addr  [N_DUT];
  logic [15:0] req_wdata [N_DUT];
  logic        rsp_valid [N_DUT];
  logic        rsp_ready [N_DUT];
  logic [15:0] rsp_rdata [N_DUT];
  logic        rsp_err   [N_DUT];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    mem_responder #(
      .DATA_W      (16),
      .ADDR_W      (8),
      .DEPTH       (depth_of(g)),
      .WAIT_CYCLES (wait_of(g))
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  typedef struct {
    int          acc;   // cycle index of the accepting edge
    logic [15:0] data;
    logic        err;
    bit          chk;   // data known to the model
  } exp_t;

  exp_t        sbq [N_DUT][$];
  logic [15:0] mm  [N_DUT][256];
  bit          kn  [N_DUT][256];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: compare every response cycle against the queue head and retire
  // the entry once rsp_valid falls.
  for (genvar g = 0; g < N_DUT; g++) begin : g_mon
    logic prev_valid = 1'b0;
    always @(negedge clk) begin : p_mon
      exp_t e;
      if (rsp_valid[g]) begin
        if (sbq[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: dut %0d rsp_valid=1, expected no response", g);
        end else begin
          e = sbq[g][0];
          if (e.chk) chk($sformatf("rsp_rdata[%0d]", g), 32'(rsp_rdata[g]), 32'(e.data));
          chk($sformatf("rsp_err[%0d]", g), 32'(rsp_err[g]), 32'(e.err));
          chk($sformatf("ready_in_resp[%0d]", g), 32'(req_ready[g]), 32'd0);
          if (!prev_valid)
            chk($sformatf("latency[%0d]", g), 32'(cyc), 32'(e.acc + wait_of(g) + 1));
        end
      end else if (prev_valid && sbq[g].size() > 0) begin
        void'(sbq[g].pop_front());
      end
      prev_valid = rsp_valid[g];
    end
  end

  // One complete transaction on instance k. Call at a negedge; returns at
  // the negedge after the response handshake. bp is the number of response
  // cycles held off with rsp_ready=0.
  task automatic xact(input int k, input bit we, input logic [7:0] addr,
                      input logic [15:0] wd, input int bp, output int acc);
    exp_t e;
    int   n;
    int   held;
    e.err  = (int'(addr) >= depth_of(k));
    e.data = 16'h0000;
    e.chk  = 1'b1;
    e.acc  = 0;
    acc    = -1;
    if (!e.err) begin
      if (we) begin
        mm[k][addr] = wd;
        kn[k][addr] = 1'b1;
      end else begin
        e.data = mm[k][addr];
        e.chk  = kn[k][addr];
      end
    end
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    rsp_ready[k] = (bp == 0);
    n = 0;
    while (!req_ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: dut %0d req_ready=0, expected 1", k);
      req_valid[k] = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    acc   = e.acc;
    sbq[k].push_back(e);
    @(negedge clk);
    n    = 0;
    held = 0;
    while (n < 40) begin
      if (rsp_valid[k]) begin
        if (held >= bp) begin
          rsp_ready[k] = 1'b1;
          req_valid[k] = 1'b0;
          break;
        end
        held++;
        rsp_ready[k] = 1'b0;
      end else begin
        chk($sformatf("ready_in_wait[%0d]", k), 32'(req_ready[k]), 32'd0);
      end
      // Request-side inputs must be ignored while busy.
      req_valid[k] = 1'($urandom_range(0, 1));
      req_we[k]    = 1'($urandom_range(0, 1));
      req_addr[k]  = 8'($urandom);
      req_wdata[k] = 16'($urandom);
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: dut %0d rsp_valid=0, expected 1", k);
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b1;
    end
    @(negedge clk);
    chk($sformatf("rsp_valid_clear[%0d]", k), 32'(rsp_valid[k]), 32'd0);
    chk($sformatf("rsp_rdata_clear[%0d]", k), 32'(rsp_rdata[k]), 32'd0);
    chk($sformatf("rsp_err_clear[%0d]", k), 32'(rsp_err[k]), 32'd0);
    chk($sformatf("ready_after_rsp[%0d]", k), 32'(req_ready[k]), 32'd1);
  endtask

  initial begin : p_stim
    int          acc;
    int          acc_prev;
    logic [7:0]  ra;
    for (int k = 0; k < N_DUT; k++) begin
      req_valid[k] = 1'b1;
      req_we[k]    = 1'b0;
      req_addr[k]  = 8'h00;
      req_wdata[k] = 16'h0000;
      rsp_ready[k] = 1'b1;
    end
    reset = 1'b0;
    #10;
    for (int k = 0; k < N_DUT; k++) begin
      chk("reset_req_ready", 32'(req_ready[k]), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
      chk("reset_rsp_rdata", 32'(rsp_rdata[k]), 32'd0);
      chk("reset_rsp_err", 32'(rsp_err[k]), 32'd0);
    end
    #2.5;
    reset = 1'b1;
    for (int k = 0; k < N_DUT; k++) req_valid[k] = 1'b0;
    #1.5;
    for (int k = 0; k < N_DUT; k++) chk("ready_before_edge", 32'(req_ready[k]), 32'd0);
    @(negedge clk);
    for (int k = 0; k < N_DUT; k++) chk("ready_after_release", 32'(req_ready[k]), 32'd1);

    // WAIT_CYCLES=2, DEPTH=200
    xact(0, 1'b1, 8'h10, 16'hBEEF, 0, acc);
    xact(0, 1'b0, 8'h10, 16'h0000, 0, acc);
    xact(0, 1'b0, 8'h10, 16'h0000, 5, acc);
    xact(0, 1'b1, 8'h48, 16'h4848, 0, acc);
    xact(0, 1'b1, 8'hC8, 16'h1234, 0, acc);
    xact(0, 1'b0, 8'h48, 16'h0000, 0, acc);
    xact(0, 1'b0, 8'hC8, 16'h0000, 2, acc);
    xact(0, 1'b1, 8'hC7, 16'h00C7, 0, acc);
    xact(0, 1'b0, 8'hC7, 16'h0000, 0, acc);

    // WAIT_CYCLES=0: back-to-back reads with minimum round trip
    for (int i = 0; i < 4; i++) xact(1, 1'b1, 8'(i), 16'(i + 1), 0, acc);
    acc_prev = -1;
    for (int i = 0; i < 4; i++) begin
      xact(1, 1'b0, 8'(i), 16'h0000, 0, acc);
      if (acc_prev >= 0) chk("round_trip_w0", 32'(acc - acc_prev), 32'd3);
      acc_prev = acc;
    end

    // WAIT_CYCLES=4, DEPTH=256: top address in range, reset mid-write
    xact(2, 1'b1, 8'h20, 16'h5555, 0, acc);
    xact(2, 1'b1, 8'hFF, 16'hF00F, 0, acc);
    xact(2, 1'b0, 8'hFF, 16'h0000, 1, acc);
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 8'h20;
    req_wdata[2] = 16'hAAAA;
    rsp_ready[2] = 1'b1;
    @(negedge clk);
    req_valid[2] = 1'b0;
    chk("ready_mid_write", 32'(req_ready[2]), 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    chk("abort_req_ready", 32'(req_ready[2]), 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("ready_after_abort", 32'(req_ready[2]), 32'd1);
    xact(2, 1'b0, 8'h20, 16'h0000, 0, acc);

    // Randomised traffic on every instance
    for (int k = 0; k < N_DUT; k++) begin
      for (int i = 0; i < 20; i++) begin
        ra = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
        xact(k, 1'($urandom_range(0, 1)), ra, 16'($urandom), int'($urandom_range(0, 3)), acc);
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 200 us");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
